// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC, issues one outstanding request to
// instruction memory and hands a single buffered instruction to the decoder.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    localparam logic [2:0] ISSUE  = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [15:0] fetch_pc, fetch_pc_nxt;
    logic        halt_pend, halt_pend_nxt;
    logic        capture, drop;

    // fetch_pc is itself a flop, so the address output stays registered
    assign imem_addr = fetch_pc;
    assign pc_plus2  = pc_out + 16'd2;

    // ISSUE with imem_req still low only occurs right after reset; the
    // request goes out on the following cycle before moving to WAIT.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        halt_pend_nxt = halt_pend;
        capture       = 1'b0;
        drop          = 1'b0;

        if (redirect && state != HALTED) begin
            fetch_pc_nxt  = {redirect_pc[15:1], 1'b0};
            halt_pend_nxt = 1'b0;
        end

        case (state)
            ISSUE: begin
                if (imem_req) begin
                    state_nxt = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_nxt = imem_valid ? ISSUE : DRAIN;
                end else if (imem_valid) begin
                    capture       = 1'b1;
                    fetch_pc_nxt  = fetch_pc + PC_INC;
                    halt_pend_nxt = (imem_data[15:12] == 4'hF);
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    drop      = 1'b1;
                    state_nxt = ISSUE;
                end else if (instr_ready) begin
                    drop      = 1'b1;
                    state_nxt = halt_pend ? HALTED : ISSUE;
                end
            end
            DRAIN: begin
                if (imem_valid) begin
                    state_nxt = ISSUE;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ISSUE;
            fetch_pc    <= RESET_PC;
            halt_pend   <= 1'b0;
            imem_req    <= 1'b0;
            instr       <= 16'h0000;
            pc_out      <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            halt_pend <= halt_pend_nxt;
            imem_req  <= (state_nxt == ISSUE);
            halted    <= (state_nxt == HALTED);
            if (capture) begin
                instr       <= imem_data;
                pc_out      <= fetch_pc;
                instr_valid <= 1'b1;
            end else if (drop) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the 16-bit ISA; sits directly upstream of the instruction decoder.
- Drives the program counter and issues requests to instruction memory, which has variable latency and one request outstanding at a time.
- Buffers one fetched instruction and presents it to the decoder's 16-bit operation input with a valid/ready handshake.
- Applies redirects for branch, call and return, and stops fetching after a HALT (opcode 4'b1111) is consumed.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0
PC_INC, 2, byte increment per instruction (16-bit instructions, byte-addressed)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  16  fetch address; valid when imem_req=1; bit 0 always 0
imem_valid  in  1  response strobe, 1..N cycles after imem_req
imem_data  in  16  instruction word, valid with imem_valid
instr  out  16  instruction to decoder (operation)
instr_valid  out  1  instr/pc_out valid
instr_ready  in  1  decoder accepts instr this cycle
pc_out  out  16  address of instr
pc_plus2  out  16  pc_out+2, return address for CALL
redirect  in  1  resolved branch-taken/CALL/RET from later stage
redirect_pc  in  16  new PC; bit 0 ignored (forced 0)
halted  out  1  HALT consumed; fetch stopped

Behaviour:
- Registers: fetch_pc[15:0], state, instr, pc_out, halt_pend. All outputs registered except pc_plus2 (=pc_out+2, mod 2^16).
- Reset: fetch_pc=RESET_PC, state=ISSUE, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, pc_out=0, halted=0, halt_pend=0. Reset overrides everything, including mid-transaction. Memory shares rst, so no stale response follows reset.
- States:
  - ISSUE: imem_req=1, imem_addr=fetch_pc for exactly one cycle, then WAIT. imem_valid arriving in ISSUE is ignored.
  - WAIT: on imem_valid, capture instr=imem_data and pc_out=fetch_pc; set fetch_pc+=PC_INC (wraps 16'hFFFE->16'h0000); set instr_valid=1, halt_pend=(imem_data[15:12]==4'hF); go to HOLD.
  - HOLD: instr_valid=1. On instr_ready, drop instr_valid next cycle. If halt_pend, go to HALTED; otherwise go to ISSUE.
  - DRAIN: wait for the squashed response. On imem_valid, discard the data and go to ISSUE.
  - HALTED: imem_req=0, instr_valid=0, halted=1. Only rst exits this state; redirect is ignored.
- Latency: ISSUE at cycle t, imem_valid at t+k, instr_valid at t+k+1. Best-case throughput is 1 instruction per 3 cycles (k=1, instr_ready held high).
- Redirect (all states except HALTED): fetch_pc <= {redirect_pc[15:1],1'b0}; halt_pend cleared.
  - ISSUE: the request is already out; go to DRAIN.
  - WAIT without imem_valid: go to DRAIN.
  - WAIT with imem_valid in the same cycle: discard the data, go to ISSUE.
  - HOLD: flush the held instruction (instr_valid=0 next cycle) even if instr_ready=1 in the same cycle, since the held instruction is younger than the redirecting one. Go to ISSUE.
  - DRAIN: stay in DRAIN with the new PC; if imem_valid arrives in the same cycle, go to ISSUE with the new PC.
- Redirect has priority over instr_ready and imem_valid. Successive redirects: last one wins.
- instr, pc_out and instr_valid are stable while instr_valid=1 and instr_ready=0.
- A HALT still in HOLD can be flushed by a redirect; only an accepted HALT stops fetch.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset then straight-line fetch:
  - Stimulus: memory returns 16'h0123 at 0x0000 and 16'h1456 at 0x0002 with k=1; instr_ready=1.
  - Required: imem_req at cycles 1 and 4, imem_addr 0x0000 then 0x0002; instr 16'h0123 with pc_out 0x0000, then 16'h1456 with pc_out 0x0002 and pc_plus2 0x0004.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles after instr_valid rises.
  - Required: instr, pc_out and instr_valid held constant; no imem_req issued; next request to pc_out+2 only after the accept.
- Redirect during WAIT:
  - Stimulus: request to 0x0010 with k=4; redirect=1, redirect_pc=0x0041 in the second WAIT cycle.
  - Required: the 0x0010 response is discarded and never appears on instr; next imem_addr=0x0040.
- Redirect vs accept in HOLD:
  - Stimulus: instr_valid=1 with pc_out 0x0020; redirect=1 (0x0100) and instr_ready=1 in the same cycle.
  - Required: instr_valid=0 next cycle; next request to 0x0100.
- HALT:
  - Stimulus: fetch 16'hF000 at 0x0006; accept it; then hold redirect=1.
  - Required: halted=1 on the cycle after the accept; no further imem_req; redirect ignored; rst returns the PC to 0x0000.
- Wrap and reset mid-transaction:
  - Stimulus: redirect to 0xFFFE and fetch it; then assert rst during WAIT.
  - Required: the next fetch address after 0xFFFE is 0x0000; after rst, instr_valid=0 and the first request is to RESET_PC.
